// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg : opcodes, controller state codes and fetch-path encodings    |
// | Revision: 2.0                                                         |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDO  = 4'h1;
  localparam logic [3:0] OP_LDA  = 4'h2;
  localparam logic [3:0] OP_STO  = 4'h3;
  localparam logic [3:0] OP_PRE  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_LDM  = 4'h6;
  localparam logic [3:0] OP_ADN  = 4'h7;
  localparam logic [3:0] OP_INC  = 4'h8;
  localparam logic [3:0] OP_DEC  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_CLR  = 4'hB;
  localparam logic [3:0] OP_RETI = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [1:0] FETCH_NONE = 2'b00;
  localparam logic [1:0] FETCH_MEM  = 2'b01;
  localparam logic [1:0] FETCH_REG  = 2'b10;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'd0,
    ST_FETCH    = 5'd1,
    ST_DECODE   = 5'd2,
    ST_RD_REG1  = 5'd3,
    ST_RD_REG2  = 5'd4,
    ST_LDM1     = 5'd5,
    ST_LDM2     = 5'd6,
    ST_JMP1     = 5'd7,
    ST_JMP2     = 5'd8,
    ST_ALU      = 5'd9,
    ST_RET      = 5'd10,
    ST_OPA1     = 5'd11,
    ST_OPA2     = 5'd12,
    ST_LOAD     = 5'd13,
    ST_LOAD_END = 5'd14,
    ST_ST1      = 5'd15,
    ST_ST2      = 5'd16,
    ST_BOUND    = 5'd17,
    ST_IRQ      = 5'd18,
    ST_HALT     = 5'd19
  } state_e;

  // States that stall on mem_rdy and are guarded by the wait timer
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_OPA2) || (s == ST_LOAD) || (s == ST_ST2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ctrl_wait_timer : counts mem_rdy-low cycles, flags timeout at TMO     |
// | Revision: 2.0                                                         |
// +----------------------------------------------------------------------+
module ctrl_wait_timer #(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic rdy,
  output logic done,
  output logic timeout
);

  localparam logic [7:0] LAST = 8'(TMO - 1);

  logic [7:0] cnt_q, cnt_d;

  // start clears for the first cycle of a new wait; saturates so it never wraps
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (!rdy && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A ready in the final allowed cycle still wins over the timeout
  assign done    = rdy;
  assign timeout = !rdy && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl_fsm_v2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_ctrl_fsm_v2 : 8-bit CPU control sequencer with wait/irq/halt      |
// | Revision: 2.0                                                         |
// +----------------------------------------------------------------------+
module cpu_ctrl_fsm_v2
  import cpu_pkg::*;
#(
  parameter int OPW    = 4,
  parameter int TMO    = 15,
  parameter int IRQ_EN = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] ins,
  input  logic           mem_rdy,
  input  logic           irq,
  input  logic           resume,
  output logic           write_r,
  output logic           read_r,
  output logic           pc_en,
  output logic           pc_in,
  output logic           ac_ena,
  output logic           ram_ena,
  output logic           ram_write,
  output logic           ram_read,
  output logic           rom_ena,
  output logic           rom_read,
  output logic           ad_sel,
  output logic           im_int,
  output logic [1:0]     fetch,
  output logic           irq_ack,
  output logic           vec_load,
  output logic           pc_restore,
  output logic           illegal_op,
  output logic           halted,
  output logic           mem_err,
  output logic [4:0]     state_dbg
);

  state_e     state_q, state_d;
  logic       in_isr_q, in_isr_d;
  logic       mem_err_q, mem_err_d;
  logic [3:0] op;
  logic       tmr_start, tmr_done, tmr_timeout, irq_take;

  assign op = ins[OPW-1:OPW-4];

  generate
    if (IRQ_EN != 0) begin : g_irq
      assign irq_take = irq && !in_isr_q;
    end else begin : g_no_irq
      logic unused_irq;
      assign unused_irq = irq;
      assign irq_take   = 1'b0;
    end
    if (OPW > 4) begin : g_op_low
      logic unused_low;
      assign unused_low = ^ins[OPW-5:0];
    end
  endgenerate

  assign tmr_start = is_wait_state(state_d) && (state_d != state_q);

  ctrl_wait_timer #(.TMO(TMO)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (tmr_start),
    .rdy     (mem_rdy),
    .done    (tmr_done),
    .timeout (tmr_timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      in_isr_q  <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_isr_q  <= in_isr_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_isr_d   = in_isr_q;
    mem_err_d  = mem_err_q;
    write_r    = 1'b0;
    read_r     = 1'b0;
    pc_en      = 1'b0;
    pc_in      = 1'b0;
    ac_ena     = 1'b0;
    ram_ena    = 1'b0;
    ram_write  = 1'b0;
    ram_read   = 1'b0;
    rom_ena    = 1'b0;
    rom_read   = 1'b0;
    ad_sel     = 1'b0;
    im_int     = 1'b0;
    fetch      = FETCH_NONE;
    irq_ack    = 1'b0;
    vec_load   = 1'b0;
    pc_restore = 1'b0;
    illegal_op = 1'b0;
    halted     = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        rom_ena  = 1'b1;
        rom_read = 1'b1;
        fetch    = FETCH_MEM;
        if (tmr_done) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        pc_en    = 1'b1;
        rom_ena  = 1'b1;
        rom_read = 1'b1;
        im_int   = (op == OP_ADN) || (op == OP_CLR);
        case (op)
          OP_NOP:                         state_d = ST_BOUND;
          OP_HLT:                         state_d = ST_HALT;
          OP_PRE, OP_ADD:                 state_d = ST_RD_REG1;
          OP_LDM:                         state_d = ST_LDM1;
          OP_JMP:                         state_d = ST_JMP1;
          OP_INC, OP_DEC, OP_ADN, OP_CLR: state_d = ST_ALU;
          OP_LDO, OP_LDA, OP_STO:         state_d = ST_OPA1;
          OP_RETI: begin
            // Returning without an active ISR has no shadow PC to restore
            if (in_isr_q) begin
              state_d = ST_RET;
            end else begin
              illegal_op = 1'b1;
              state_d    = ST_BOUND;
            end
          end
          default: begin
            illegal_op = 1'b1;
            state_d    = ST_BOUND;
          end
        endcase
      end
      ST_RD_REG1: begin
        read_r  = 1'b1;
        ac_ena  = 1'b1;
        fetch   = FETCH_REG;
        state_d = ST_RD_REG2;
      end
      ST_RD_REG2: begin
        read_r  = 1'b1;
        state_d = ST_BOUND;
      end
      ST_LDM1: begin
        ram_ena  = 1'b1;
        ram_read = 1'b1;
        ad_sel   = 1'b1;
        state_d  = ST_LDM2;
      end
      ST_LDM2: begin
        write_r = 1'b1;
        ac_ena  = 1'b1;
        state_d = ST_BOUND;
      end
      ST_JMP1: begin
        pc_en    = 1'b1;
        pc_in    = 1'b1;
        rom_ena  = 1'b1;
        rom_read = 1'b1;
        fetch    = FETCH_MEM;
        state_d  = ST_JMP2;
      end
      ST_JMP2: begin
        rom_ena  = 1'b1;
        rom_read = 1'b1;
        state_d  = ST_BOUND;
      end
      ST_ALU: begin
        ac_ena   = 1'b1;
        rom_ena  = 1'b1;
        rom_read = 1'b1;
        state_d  = ST_BOUND;
      end
      ST_RET: begin
        pc_restore = 1'b1;
        in_isr_d   = 1'b0;
        state_d    = ST_BOUND;
      end
      ST_OPA1, ST_OPA2: begin
        ac_ena   = 1'b1;
        rom_ena  = 1'b1;
        rom_read = 1'b1;
        fetch    = FETCH_REG;
        if (state_q == ST_OPA1) begin
          state_d = ST_OPA2;
        end else begin
          pc_en = 1'b1;
          if (tmr_done) begin
            if (op == OP_STO)                        state_d = ST_ST1;
            else if ((op == OP_LDO) || (op == OP_LDA)) state_d = ST_LOAD;
            else                                     state_d = ST_BOUND;
          end
        end
      end
      ST_LOAD: begin
        write_r = 1'b1;
        ac_ena  = 1'b1;
        ad_sel  = 1'b1;
        fetch   = FETCH_MEM;
        if (op == OP_LDA) begin
          ram_ena  = 1'b1;
          ram_read = 1'b1;
        end else begin
          rom_ena  = 1'b1;
          rom_read = 1'b1;
        end
        if (tmr_done) state_d = ST_LOAD_END;
      end
      ST_LOAD_END: state_d = ST_BOUND;
      ST_ST1: begin
        read_r  = 1'b1;
        state_d = ST_ST2;
      end
      ST_ST2: begin
        read_r    = 1'b1;
        ram_ena   = 1'b1;
        ram_write = 1'b1;
        ad_sel    = 1'b1;
        if (tmr_done) state_d = ST_BOUND;
      end
      ST_BOUND: state_d = irq_take ? ST_IRQ : ST_FETCH;
      ST_IRQ: begin
        irq_ack  = 1'b1;
        vec_load = 1'b1;
        pc_in    = 1'b1;
        in_isr_d = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        // An interrupt wake-up goes through BOUND so the vector is taken there
        if (irq_take || resume) state_d = ST_BOUND;
      end
      default: state_d = ST_IDLE;
    endcase

    if (is_wait_state(state_q) && tmr_timeout) begin
      state_d   = ST_HALT;
      mem_err_d = 1'b1;
    end
  end

  assign mem_err   = mem_err_q;
  assign state_dbg = state_q;

endmodule
`default_nettype wire
